ex_muldiv_unit: RTL and testbench
=================================

// Module: ex_muldiv_unit
// PURPOSE
//  Parametrised multi-cycle RV32M/RV64M execute unit beside the EX-stage ALU.
//  - Executes MUL/MULH/MULHSU/MULHU through a MUL_CYCLES-deep registered path.
//  - Executes DIV/DIVU/REM/REMU with a radix-2 restoring divider.
//  - valid/ready on both sides; busy drives the hazard unit's EX stall.
//  - flush squashes in-flight work on branch mispredict.
// PARAMETERS
//  XLEN            32  operand/result width (32 or 64)
//  MUL_CYCLES      2   multiply latency in cycles, 1..4
//  REG_ADDR_WIDTH  5   width of rd tag carried with the op
// PORTS
//  clk         in   1               rising-edge clock
//  reset_n     in   1               asynchronous, active-low reset
//  in_valid    in   1               op presented
//  in_ready    out  1               unit can accept op
//  in_funct3   in   3               000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  in_a        in   XLEN            rs1 (forwarded)
//  in_b        in   XLEN            rs2 (forwarded)
//  in_rd       in   REG_ADDR_WIDTH  destination tag
//  flush       in   1               kill in-flight op
//  out_valid   out  1               result valid
//  out_ready   in   1               consumer (EX/MEM) takes result
//  out_result  out  XLEN            result
//  out_rd      out  REG_ADDR_WIDTH  tag of result
//  busy        out  1               op in flight or result not yet taken
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE; out_valid=0, out_result=0, out_rd=0, busy=0, counters=0.
//  Reset mid-operation abandons the op; no out_valid after release.
//  FSM states: IDLE, MUL, DIV, DONE.
//  Transfers:
//  - in_ready = (state==IDLE) && !flush.
//  - Accept on in_valid && in_ready.
//  - Result leaves on out_valid && out_ready.
//  - out_result and out_rd stay stable while out_valid=1 and out_ready=0.
//  IDLE: on accept, latch funct3, rd, operands.
//  - funct3[2]=0: go to MUL.
//  - funct3[2]=1, b==0: go to DONE next cycle with the divide-by-zero result.
//  - funct3[2]=1, signed overflow (a=MIN_INT, b=-1, funct3 100/110): go to DONE next cycle.
//  - Otherwise go to DIV.
//  MUL: full 2*XLEN product of sign/zero-extended operands.
//  - MULHSU: a signed, b unsigned.
//  - Counter runs MUL_CYCLES-1 cycles, then DONE.
//  - out_valid first high at accept-cycle + MUL_CYCLES.
//  - MUL returns product[XLEN-1:0]; MULH* return product[2XLEN-1:XLEN].
//  DIV: operate on |a|, |b| for signed ops.
//  - One quotient bit per cycle, XLEN iterations.
//  - Sign fixup registered into DONE: out_valid at accept-cycle + XLEN + 1.
//  - Quotient sign = sign(a)^sign(b); remainder sign = sign(a).
//  Special cases (RISC-V spec), out_valid at accept-cycle + 1:
//  - x/0: DIV/DIVU -> all ones; REM/REMU -> a.
//  - MIN_INT/-1: DIV -> MIN_INT; REM -> 0.
//  DONE: out_valid=1.
//  - out_ready=1 -> IDLE next cycle; in_ready is high one cycle later.
//  - No same-cycle retire+accept.
//  flush: any state -> IDLE next cycle; out_valid low next cycle.
//  - An op offered with flush=1 is not accepted.
//  - flush with out_valid && out_ready in the same cycle: the transfer is not counted; the consumer ignores it.
//  busy = (state != IDLE). All outputs are registered except in_ready and busy, which decode state.
// TESTING
//  1 MUL a=7,b=0xFFFFFFFD, MUL_CYCLES=2 -> out_valid at t+2, result 0xFFFFFFEB, rd echoed.
//  2 MULH/MULHSU/MULHU a=b=0x80000000 -> 0x40000000 / 0xC0000000 / 0x40000000.
//  3 DIV/REM a=0x80000000,b=0xFFFFFFFF -> 0x80000000 / 0, out_valid at t+1.
//    DIVU/REMU 5/0 -> 0xFFFFFFFF / 5, out_valid at t+1.
//  4 DIVU 100/7 -> 14 at t+33; DIV -100/7 -> 0xFFFFFFF2; REM -100/7 -> 0xFFFFFFFE.
//    out_ready low 5 cycles -> result held stable, busy=1, in_ready=0.
//  5 flush at DIV iteration 10 -> no out_valid; in_ready=1 next cycle.
//    Next MUL 3*4 -> 12 at correct latency.
//  6 reset_n low mid-DIV -> outputs 0 immediately (async).
//    After release: in_ready=1, no stale out_valid.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// RV32M/RV64M multiply/divide execute unit: multi-cycle multiply, radix-2 restoring divide,
// valid/ready on both sides, flush squashes in-flight work.
module ex_muldiv_unit #(
  parameter int XLEN           = 32,
  parameter int MUL_CYCLES     = 2,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2:0]                in_funct3,
  input  logic [XLEN-1:0]           in_a,
  input  logic [XLEN-1:0]           in_b,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           out_result,
  output logic [REG_ADDR_WIDTH-1:0] out_rd,
  output logic                      busy
);

  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'((MUL_CYCLES > 1) ? (MUL_CYCLES - 2) : 0);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        out_valid_q, out_valid_d;
  logic [XLEN-1:0]             out_result_q, out_result_d;
  logic [REG_ADDR_WIDTH-1:0]   out_rd_q, out_rd_d;

  logic [1:0]                  op_q, op_d;
  logic [REG_ADDR_WIDTH-1:0]   rd_q, rd_d;
  logic [XLEN-1:0]             a_q, a_d, b_q, b_d, rem_q, rem_d;
  logic                        qneg_q, qneg_d, rneg_q, rneg_d;

  // Full 2*XLEN product; op[1:0]: 00 MUL, 01 MULH (s*s), 10 MULHSU (s*u), 11 MULHU (u*u).
  function automatic logic [2*XLEN-1:0] mul_full(input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b,
                                                 input logic [1:0]      op);
    logic                      a_sgn, b_sgn;
    logic signed [2*XLEN-1:0]  ea, eb, p;
    a_sgn = (op == 2'b01) || (op == 2'b10);
    b_sgn = (op == 2'b01);
    ea = $signed({{XLEN{a_sgn & a[XLEN-1]}}, a});
    eb = $signed({{XLEN{b_sgn & b[XLEN-1]}}, b});
    p  = ea * eb;
    return p;
  endfunction

  function automatic logic [XLEN-1:0] mul_select(input logic [2*XLEN-1:0] prod,
                                                 input logic [1:0]        op);
    return (op == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  endfunction

  function automatic logic [XLEN-1:0] sign_fix(input logic [XLEN-1:0] mag, input logic neg);
    return neg ? ({XLEN{1'b0}} - mag) : mag;
  endfunction

  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic sgn);
    return sign_fix(v, sgn & v[XLEN-1]);
  endfunction

  logic                 accept, signed_div, div_ovf;
  logic [XLEN-1:0]      mop_a, mop_b;
  logic [1:0]           mop_op;
  logic [2*XLEN-1:0]    prod;
  logic [XLEN:0]        shifted;
  logic [XLEN-1:0]      sub, rem_next, quo_next;
  logic                 qbit;

  assign in_ready   = (state_q == IDLE) && !flush;
  assign busy       = (state_q != IDLE);
  assign accept     = in_valid && in_ready;
  assign signed_div = !in_funct3[0];
  assign div_ovf    = signed_div && (in_a == MIN_INT) && (in_b == {XLEN{1'b1}});

  // Single multiplier: fed from the ports at accept (MUL_CYCLES==1) or from latched operands.
  assign mop_a  = (state_q == IDLE) ? in_a : a_q;
  assign mop_b  = (state_q == IDLE) ? in_b : b_q;
  assign mop_op = (state_q == IDLE) ? in_funct3[1:0] : op_q;
  assign prod   = mul_full(mop_a, mop_b, mop_op);

  // Restoring step: a_q shifts the dividend out MSB-first and the quotient in LSB-first.
  assign shifted  = {rem_q, a_q[XLEN-1]};
  assign qbit     = (shifted >= {1'b0, b_q});
  assign sub      = shifted[XLEN-1:0] - b_q;
  assign rem_next = qbit ? sub : shifted[XLEN-1:0];
  assign quo_next = {a_q[XLEN-2:0], qbit};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_rd_d     = out_rd_q;
    op_d         = op_q;
    rd_d         = rd_q;
    a_d          = a_q;
    b_d          = b_q;
    rem_d        = rem_q;
    qneg_d       = qneg_q;
    rneg_d       = rneg_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_d  = in_funct3[1:0];
          rd_d  = in_rd;
          cnt_d = '0;
          if (!in_funct3[2]) begin
            a_d = in_a;
            b_d = in_b;
            if (MUL_CYCLES == 1) begin
              out_result_d = mul_select(prod, in_funct3[1:0]);
              out_rd_d     = in_rd;
              out_valid_d  = 1'b1;
              state_d      = DONE;
            end else begin
              state_d = MUL;
            end
          end else if (in_b == '0) begin
            out_result_d = in_funct3[1] ? in_a : {XLEN{1'b1}};
            out_rd_d     = in_rd;
            out_valid_d  = 1'b1;
            state_d      = DONE;
          end else if (div_ovf) begin
            out_result_d = in_funct3[1] ? {XLEN{1'b0}} : MIN_INT;
            out_rd_d     = in_rd;
            out_valid_d  = 1'b1;
            state_d      = DONE;
          end else begin
            a_d     = abs_val(in_a, signed_div);
            b_d     = abs_val(in_b, signed_div);
            rem_d   = '0;
            qneg_d  = signed_div & (in_a[XLEN-1] ^ in_b[XLEN-1]);
            rneg_d  = signed_div & in_a[XLEN-1];
            state_d = DIV;
          end
        end
      end
      MUL: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == MUL_LAST) begin
          out_result_d = mul_select(prod, op_q);
          out_rd_d     = rd_q;
          out_valid_d  = 1'b1;
          cnt_d        = '0;
          state_d      = DONE;
        end
      end
      DIV: begin
        a_d   = quo_next;
        rem_d = rem_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == DIV_LAST) begin
          out_result_d = op_q[1] ? sign_fix(rem_next, rneg_q) : sign_fix(quo_next, qneg_q);
          out_rd_d     = rd_q;
          out_valid_d  = 1'b1;
          cnt_d        = '0;
          state_d      = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      cnt_d       = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_rd_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_rd_q     <= out_rd_d;
    end
  end

  // Operand/working datapath: qualified by state, so it carries no reset.
  always_ff @(posedge clk) begin
    op_q   <= op_d;
    rd_q   <= rd_d;
    a_q    <= a_d;
    b_q    <= b_d;
    rem_q  <= rem_d;
    qneg_q <= qneg_d;
    rneg_q <= rneg_d;
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_rd     = out_rd_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit (XLEN=32, MUL_CYCLES=2): directed vectors, latency,
// hold-under-backpressure, flush and asynchronous reset.
module tb_ex_muldiv_unit;

  localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_funct3 = 3'b000;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [4:0]  in_rd = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          vcyc;
  } exp_t;
  exp_t sb[$];
  bit   rise_seen = 1'b0;

  ex_muldiv_unit #(.XLEN(32), .MUL_CYCLES(2), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
    .in_a(in_a), .in_b(in_b), .in_rd(in_rd), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: latency on first out_valid cycle, data/tag on each transfer.
  always @(negedge clk) begin
    if (reset_n && out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: got result %0h rd %0d expected no output (cycle %0d)",
                 out_result, out_rd, cyc);
      end else begin
        if (!rise_seen) begin
          check("latency", 64'(cyc), 64'(sb[0].vcyc));
          rise_seen = 1'b1;
        end
        if (out_ready && !flush) begin
          check("result", 64'(out_result), 64'(sb[0].res));
          check("rd", 64'(out_rd), 64'(sb[0].rd));
          void'(sb.pop_front());
          rise_seen = 1'b0;
        end
      end
    end
  end

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] res, input int lat,
                       input bit push);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: got in_ready 0 expected 1 (cycle %0d)", cyc);
      return;
    end
    in_valid  = 1'b1;
    in_funct3 = f;
    in_a      = a;
    in_b      = b;
    in_rd     = rd;
    if (push) sb.push_back('{res, rd, cyc + lat});
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
      rise_seen = 1'b0;
    end
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_result", 64'(out_result), 64'd0);
    check("rst_out_rd", 64'(out_rd), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    reset_n = 1'b1;

    issue(F_MUL, 32'd7, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB, 2, 1'b1);
    issue(F_MULH,   32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, 2, 1'b1);
    issue(F_MULHSU, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'hC000_0000, 2, 1'b1);
    issue(F_MULHU,  32'h8000_0000, 32'h8000_0000, 5'd7, 32'h4000_0000, 2, 1'b1);

    issue(F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1, 1'b1);
    issue(F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h0000_0000, 1, 1'b1);
    issue(F_DIVU, 32'd5, 32'd0, 5'd12, 32'hFFFF_FFFF, 1, 1'b1);
    issue(F_REMU, 32'd5, 32'd0, 5'd13, 32'd5, 1, 1'b1);
    issue(F_DIV,  32'hFFFF_FFF6, 32'd0, 5'd14, 32'hFFFF_FFFF, 1, 1'b1);

    issue(F_DIVU, 32'd100, 32'd7, 5'd15, 32'd14, 33, 1'b1);
    issue(F_DIV,  32'hFFFF_FF9C, 32'd7, 5'd16, 32'hFFFF_FFF2, 33, 1'b1);
    issue(F_REM,  32'hFFFF_FF9C, 32'd7, 5'd17, 32'hFFFF_FFFE, 33, 1'b1);
    issue(F_REMU, 32'd100, 32'd7, 5'd18, 32'd2, 33, 1'b1);
    issue(F_DIV,  32'd100, 32'hFFFF_FFF9, 5'd19, 32'hFFFF_FFF2, 33, 1'b1);
    issue(F_REM,  32'd100, 32'hFFFF_FFF9, 5'd20, 32'd2, 33, 1'b1);
    drain();

    // Backpressure: result must hold while out_ready is low.
    @(posedge clk);
    #1 out_ready = 1'b0;
    issue(F_DIVU, 32'd100, 32'd7, 5'd9, 32'd14, 33, 1'b1);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("hold_seen_valid", 64'(out_valid), 64'd1);
    repeat (5) begin
      @(negedge clk);
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_result", 64'(out_result), 64'd14);
      check("hold_rd", 64'(out_rd), 64'd9);
      check("hold_busy", 64'(busy), 64'd1);
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    // An op offered together with flush is refused.
    @(negedge clk);
    in_valid = 1'b1; in_funct3 = F_MUL; in_a = 32'd2; in_b = 32'd2; in_rd = 5'd1; flush = 1'b1;
    #1 check("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    flush = 1'b0;
    check("flush_not_accepted", 64'(busy), 64'd0);

    // Flush during the divide iterations.
    issue(F_DIV, 32'd1000, 32'd3, 5'd21, 32'd333, 33, 1'b0);
    repeat (10) @(negedge clk);
    check("pre_flush_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("post_flush_in_ready", 64'(in_ready), 64'd1);
    check("post_flush_busy", 64'(busy), 64'd0);
    check("post_flush_valid", 64'(out_valid), 64'd0);
    repeat (40) @(negedge clk);
    issue(F_MUL, 32'd3, 32'd4, 5'd6, 32'd12, 2, 1'b1);
    drain();

    // Asynchronous reset in the middle of a divide.
    issue(F_DIVU, 32'd100, 32'd7, 5'd4, 32'd14, 33, 1'b0);
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_result", 64'(out_result), 64'd0);
    check("async_rst_rd", 64'(out_rd), 64'd0);
    check("async_rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1 check("post_rst_in_ready", 64'(in_ready), 64'd1);
    repeat (40) @(negedge clk);
    check("post_rst_no_valid", 64'(out_valid), 64'd0);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
